gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog: RTL
=========================================

GF180MCU_FD_SC_MCU7T5V0__CLKDIV_PROG -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog

Interface
REQ-001 Parameter WIDTH, 4, width of the division-ratio input and period counter; legal range 2..16.
REQ-002 Parameter INVERT, 1, output polarity: 1 means Z is the inverted divided clock, 0 means true polarity.
REQ-003 CLK  input  1  source clock; all state updates on rising edge; one clock only.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 EN  input  1  divider enable, sampled on CLK.
REQ-006 DIV  input  WIDTH  requested division ratio N, unsigned.
REQ-007 Z  output  1  registered divided clock, polarity per INVERT.
REQ-008 TICK  output  1  one-CLK pulse marking each divided-clock rising phase start.
REQ-009 BUSY  output  1  high whenever the divider is not in IDLE.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, HI, LO.
REQ-011 Internal divided clock q SHALL be 0 in IDLE, 1 in HI, 0 in LO; Z SHALL equal q XOR INVERT, driven directly from a flop, with no combinational path from CLK.
REQ-012 The effective ratio n SHALL be max(DIV,2); DIV values 0 and 1 are clamped to 2.
REQ-013 DIV SHALL be captured into a shadow register only on entry to HI; DIV changes mid-period SHALL NOT affect the current period.
REQ-014 HI SHALL last floor(n/2) CLK cycles; LO SHALL last n-floor(n/2) cycles; period = n cycles exactly.
REQ-015 IDLE with EN=1 at a rising edge SHALL enter HI at that edge (latency 1 cycle from EN sample to Z transition).
REQ-016 At the last LO cycle: EN=1 -> re-capture DIV, enter HI; EN=0 -> enter IDLE.
REQ-017 EN deassertion during HI or LO SHALL NOT truncate the period; the divider completes the current LO phase before IDLE (glitch-free stop).
REQ-018 TICK SHALL be 1 exactly in the first cycle of each HI phase, registered, 0 otherwise.
REQ-019 BUSY SHALL be 1 in HI and LO, 0 in IDLE.
REQ-020 Period counter SHALL be WIDTH bits, count down from phase length minus 1, never wrap; n=2^WIDTH-1 SHALL be supported.

Reset
REQ-021 RST=1 SHALL force state IDLE, counter 0, shadow ratio 2, q=0, TICK=0, BUSY=0 immediately, independent of CLK.
REQ-022 Z during and after reset SHALL be INVERT (1 for INVERT=1, 0 for INVERT=0).
REQ-023 RST asserted mid-period SHALL abort the period; after release the first HI requires EN=1 at a rising edge.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, HI, LO) and constant MIN_DIV=2.
REQ-025 The loadable down-counter with terminal-count flag SHALL be a sub-module gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt, parameterised by WIDTH.
REQ-026 The top SHALL contain the state machine, shadow register, clamp and output flops only.

Verification
REQ-027 RST pulse mid-run, INVERT=1 -> Z=1, TICK=0, BUSY=0 during RST without a CLK edge.
REQ-028 DIV=4, EN=1 held -> Z (INVERT=0) pattern 1,1,0,0 repeating; TICK every 4 cycles; first Z=1 one cycle after EN sampled.
REQ-029 DIV=5 -> HI 2 cycles, LO 3 cycles; DIV=0 and DIV=1 -> identical to DIV=2 (1 high, 1 low).
REQ-030 DIV changes 4->6 in the middle of a HI phase -> current period stays 4, next period 6 (3 high, 3 low).
REQ-031 EN dropped in the first HI cycle of DIV=6 -> full 3 HI + 3 LO completed, then IDLE, BUSY=0, no short pulse on Z.
REQ-032 WIDTH=4, DIV=15 -> HI 7, LO 8 cycles, counter never wraps, TICK period 15.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_t : divider phase (IDLE, HI, LO)
//   MIN_DIV : smallest ratio the divider will run at; DIV values below it
//             are clamped up to it.
package gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt.sv
// Loadable down-counter with terminal-count flag for the clock divider.
//   clk      : source clock, rising edge
//   rst      : asynchronous active-high reset, clears the count to 0
//   load     : load load_val on the next rising edge
//   load_val : value to load (phase length minus 1)
//   tc       : high while the count is 0 (last cycle of the current phase)
// The count saturates at 0 instead of wrapping, so the divider state machine
// stays in control of every phase boundary.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable clock divider.
//   CLK  : source clock, all state updates on its rising edge
//   RST  : asynchronous active-high reset
//   EN   : divider enable, sampled on CLK
//   DIV  : requested division ratio N (0 and 1 run as 2)
//   Z    : registered divided clock, inverted when INVERT=1
//   TICK : one-CLK pulse in the first cycle of each high phase
//   BUSY : high while the divider is running (HI or LO)
// Each period is n = max(DIV,2) cycles: floor(n/2) high, the rest low. DIV is
// captured only when a high phase starts, and a stop request (EN low) lets the
// current period run to the end of its low phase so Z never glitches.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog
  import gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit INVERT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Z,
  output logic             TICK,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state, next_state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] hi_load_new;
  logic [WIDTH-1:0] lo_load;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_load;
  logic             cnt_tc;
  logic             shadow_load;
  logic             z_q;
  logic             tick_q;
  logic             busy_q;

  // A new high phase is sized from the incoming DIV (the value being
  // captured), while the low phase uses the ratio already held in shadow.
  assign div_n       = (DIV < MIN_N) ? MIN_N : DIV;
  assign hi_load_new = (div_n >> 1) - ONE;
  assign lo_load     = shadow - (shadow >> 1) - ONE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    shadow_load = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          next_state  = HI;
          shadow_load = 1'b1;
          cnt_load    = 1'b1;
          cnt_val     = hi_load_new;
        end
      end
      HI: begin
        if (cnt_tc) begin
          next_state = LO;
          cnt_load   = 1'b1;
          cnt_val    = lo_load;
        end
      end
      LO: begin
        // Only the last low cycle decides between another period and a stop.
        if (cnt_tc) begin
          if (EN) begin
            next_state  = HI;
            shadow_load = 1'b1;
            cnt_load    = 1'b1;
            cnt_val     = hi_load_new;
          end else begin
            next_state = IDLE;
            cnt_load   = 1'b1;
            cnt_val    = '0;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= MIN_N;
    end else if (shadow_load) begin
      shadow <= div_n;
    end
  end

  // Outputs are computed from the next state so they line up with the state
  // register and leave straight from flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      z_q    <= INVERT;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      z_q    <= (next_state == HI) ^ INVERT;
      tick_q <= (next_state == HI) && (state != HI);
      busy_q <= (next_state != IDLE);
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  assign Z    = z_q;
  assign TICK = tick_q;
  assign BUSY = busy_q;

endmodule
